instr_fetch_unit: RTL and testbench

- Produces the opcode stream that the control unit decodes: holds the PC, fetches 32-bit instruction words from instruction memory over a read/busywait handshake, and presents each word for one issue window.
- Resolves the next PC from the control unit's bselect and the ALU zero flag (sequential, jump, beq, bne).
- Sits between instruction memory and the decode/execute datapath; the opcode field of its instruction output drives the control unit directly.

---
 rtl/cpu_pkg.sv | 44 ++++
 rtl/next_pc_calc.sv | 34 +++
 rtl/instr_fetch_unit.sv | 109 ++++++++++
 tb/tb_instr_fetch_unit.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcodes, branch-select encodings, fetch states and
// instruction field positions.
package cpu_pkg;

    localparam logic [7:0] OP_LOADI = 8'h00;
    localparam logic [7:0] OP_MOV   = 8'h01;
    localparam logic [7:0] OP_ADD   = 8'h02;
    localparam logic [7:0] OP_SUB   = 8'h03;
    localparam logic [7:0] OP_AND   = 8'h04;
    localparam logic [7:0] OP_OR    = 8'h05;
    localparam logic [7:0] OP_J     = 8'h06;
    localparam logic [7:0] OP_BEQ   = 8'h07;
    localparam logic [7:0] OP_BNE   = 8'h08;
    localparam logic [7:0] OP_LWD   = 8'h09;
    localparam logic [7:0] OP_LWI   = 8'h0A;
    localparam logic [7:0] OP_SWD   = 8'h0B;
    localparam logic [7:0] OP_SWI   = 8'h0C;
    localparam logic [7:0] OP_MULT  = 8'h0D;
    localparam logic [7:0] OP_SLL   = 8'h0E;
    localparam logic [7:0] OP_SRL   = 8'h0F;
    localparam logic [7:0] OP_SRA   = 8'h10;
    localparam logic [7:0] OP_ROR   = 8'h11;

    localparam logic [1:0] BSEL_NEXT = 2'b00;
    localparam logic [1:0] BSEL_JUMP = 2'b01;
    localparam logic [1:0] BSEL_BEQ  = 2'b10;
    localparam logic [1:0] BSEL_BNE  = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        ISSUE = 2'd2
    } fetch_state_e;

    localparam int unsigned OPC_MSB  = 31;
    localparam int unsigned OPC_LSB  = 24;
    localparam int unsigned DEST_MSB = 23;
    localparam int unsigned DEST_LSB = 16;
    localparam int unsigned SRC1_MSB = 15;
    localparam int unsigned SRC1_LSB = 8;
    localparam int unsigned SRC2_MSB = 7;
    localparam int unsigned SRC2_LSB = 0;

endpackage

// File: rtl/next_pc_calc.sv
// Combinational next-PC resolution: sequential, jump, beq and bne targets
// from the current PC and the signed word offset byte.
module next_pc_calc
    import cpu_pkg::*;
#(
    parameter int unsigned ADDR_W       = 32,
    parameter int unsigned OFFSET_SHIFT = 2
) (
    input  logic [ADDR_W-1:0] pc,
    input  logic [7:0]        offset,
    input  logic [1:0]        bselect,
    input  logic              zero,
    output logic [ADDR_W-1:0] next_pc_c
);

    logic [ADDR_W-1:0] pc4;
    logic [ADDR_W-1:0] off_ext;
    logic [ADDR_W-1:0] tgt;

    always_comb begin
        pc4     = pc + ADDR_W'(4);
        off_ext = {{(ADDR_W-8){offset[7]}}, offset};
        tgt     = pc4 + (off_ext << OFFSET_SHIFT);
        next_pc_c = pc4;
        case (bselect)
            BSEL_NEXT: next_pc_c = pc4;
            BSEL_JUMP: next_pc_c = tgt;
            BSEL_BEQ:  next_pc_c = zero ? tgt : pc4;
            BSEL_BNE:  next_pc_c = zero ? pc4 : tgt;
            default:   next_pc_c = pc4;
        endcase
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: holds the PC, fetches one word per issue window over
// a read/busywait handshake and resolves the next PC when the window closes.
module instr_fetch_unit
    import cpu_pkg::*;
#(
    parameter int unsigned       ADDR_W       = 32,
    parameter int unsigned       INSTR_W      = 32,
    parameter logic [ADDR_W-1:0] RESET_PC     = '0,
    parameter int unsigned       OFFSET_SHIFT = 2
) (
    input  logic               clk,
    input  logic               reset_n,
    output logic               imem_read,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               imem_busywait,
    output logic [INSTR_W-1:0] instruction,
    output logic               instr_valid,
    input  logic [1:0]         bselect,
    input  logic               zero,
    input  logic               stall,
    output logic [ADDR_W-1:0]  pc,
    output logic [31:0]        retire_count
);

    fetch_state_e       state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic               imem_read_q, imem_read_d;
    logic               valid_q, valid_d;
    logic [31:0]        retire_q, retire_d;
    logic [ADDR_W-1:0]  next_pc_c;

    next_pc_calc #(
        .ADDR_W       (ADDR_W),
        .OFFSET_SHIFT (OFFSET_SHIFT)
    ) u_next_pc_calc (
        .pc        (pc_q),
        .offset    (instr_q[DEST_MSB:DEST_LSB]),
        .bselect   (bselect),
        .zero      (zero),
        .next_pc_c (next_pc_c)
    );

    // Next-state and registered-output logic for IDLE -> FETCH <-> ISSUE.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        instr_d     = instr_q;
        imem_read_d = imem_read_q;
        valid_d     = valid_q;
        retire_d    = retire_q;
        case (state_q)
            IDLE: begin
                state_d     = FETCH;
                imem_read_d = 1'b1;
            end
            FETCH: begin
                if (!imem_busywait) begin
                    instr_d     = imem_rdata;
                    imem_read_d = 1'b0;
                    valid_d     = 1'b1;
                    state_d     = ISSUE;
                end
            end
            ISSUE: begin
                // bselect/zero are only meaningful on the edge that closes the window.
                if (!stall) begin
                    pc_d        = next_pc_c;
                    retire_d    = retire_q + 32'd1;
                    valid_d     = 1'b0;
                    imem_read_d = 1'b1;
                    state_d     = FETCH;
                end
            end
            default: begin
                state_d     = IDLE;
                imem_read_d = 1'b0;
                valid_d     = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            pc_q        <= RESET_PC;
            instr_q     <= '0;
            imem_read_q <= 1'b0;
            valid_q     <= 1'b0;
            retire_q    <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            instr_q     <= instr_d;
            imem_read_q <= imem_read_d;
            valid_q     <= valid_d;
            retire_q    <= retire_d;
        end
    end

    assign imem_read    = imem_read_q;
    assign imem_addr    = pc_q;
    assign instruction  = instr_q;
    assign instr_valid  = valid_q;
    assign pc           = pc_q;
    assign retire_count = retire_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: a driver plays memory and control
// unit from a directed table; a monitor checks every issue window.
module tb_instr_fetch_unit;

    logic        clk;
    logic        reset_n;
    logic        imem_read;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_busywait;
    logic [31:0] instruction;
    logic        instr_valid;
    logic [1:0]  bselect;
    logic        zero;
    logic        stall;
    logic [31:0] pc;
    logic [31:0] retire_count;

    int total = 0;
    int bad   = 0;

    instr_fetch_unit #(
        .ADDR_W       (32),
        .INSTR_W      (32),
        .RESET_PC     (32'h0),
        .OFFSET_SHIFT (2)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .imem_read     (imem_read),
        .imem_addr     (imem_addr),
        .imem_rdata    (imem_rdata),
        .imem_busywait (imem_busywait),
        .instruction   (instruction),
        .instr_valid   (instr_valid),
        .bselect       (bselect),
        .zero          (zero),
        .stall         (stall),
        .pc            (pc),
        .retire_count  (retire_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] retire;
        int          len;
    } exp_t;

    typedef struct {
        logic [31:0] rdata;
        logic [1:0]  bsel;
        logic        z;
        int          busy;
        int          stl;
        logic [31:0] npc;
    } vec_t;

    exp_t exp_q[$];
    logic [31:0] pc_exp;
    logic [31:0] ret_exp;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Monitor: pop one expectation per issue window, check it each valid cycle and its length.
    exp_t cur;
    bit   in_win = 0;
    int   win_cnt = 0;
    always @(negedge clk) begin
        if (!reset_n) begin
            in_win  <= 1'b0;
            win_cnt <= 0;
        end else if (instr_valid) begin
            if (!in_win) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_issue", 32'd1, 32'd0);
                    cur = '{pc: pc, instr: instruction, retire: retire_count, len: 1};
                end else begin
                    cur = exp_q.pop_front();
                end
                in_win  <= 1'b1;
                win_cnt <= 1;
            end else begin
                win_cnt <= win_cnt + 1;
            end
            check("issue_instr", instruction, cur.instr);
            check("issue_pc", pc, cur.pc);
            check("issue_retire", retire_count, cur.retire);
            check("issue_imem_read", {31'd0, imem_read}, 32'd0);
        end else if (in_win) begin
            check("window_len", 32'(win_cnt), 32'(cur.len));
            in_win <= 1'b0;
        end
    end

    task automatic wait_fetch(input string name);
        int n = 0;
        while (!imem_read && n < 50) begin
            @(negedge clk);
            n++;
        end
        check({name, "_fetch_req"}, {31'd0, imem_read}, 32'd1);
        check({name, "_fetch_addr"}, imem_addr, pc_exp);
        check({name, "_fetch_retire"}, retire_count, ret_exp);
    endtask

    task automatic run_vec(input vec_t v);
        exp_q.push_back('{pc: pc_exp, instr: v.rdata, retire: ret_exp, len: v.stl + 1});
        wait_fetch("vec");
        imem_busywait = 1'b1;
        imem_rdata    = 32'hDEAD_BEEF;
        repeat (v.busy) @(negedge clk);
        imem_busywait = 1'b0;
        imem_rdata    = v.rdata;
        @(negedge clk);
        imem_busywait = 1'b1;
        imem_rdata    = 32'hDEAD_BEEF;
        bselect = v.bsel;
        zero    = v.z;
        stall   = (v.stl > 0);
        repeat (v.stl) @(negedge clk);
        stall = 1'b0;
        @(negedge clk);
        // Deliberately misleading control inputs while outside ISSUE.
        bselect = 2'b01;
        zero    = ~v.z;
        pc_exp  = v.npc;
        ret_exp = ret_exp + 32'd1;
    endtask

    vec_t vecs[$];

    initial begin
        reset_n       = 1'b0;
        imem_rdata    = 32'h0;
        imem_busywait = 1'b1;
        bselect       = 2'b00;
        zero          = 1'b0;
        stall         = 1'b0;
        pc_exp        = 32'h0;
        ret_exp       = 32'h0;

        vecs.push_back('{32'h0002_0005, 2'b00, 1'b0, 2, 0, 32'h0000_0004});
        vecs.push_back('{32'h0100_0000, 2'b00, 1'b0, 0, 0, 32'h0000_0008});
        vecs.push_back('{32'h06FE_0000, 2'b01, 1'b0, 0, 0, 32'h0000_0004});
        vecs.push_back('{32'h0602_0000, 2'b01, 1'b0, 1, 0, 32'h0000_0010});
        vecs.push_back('{32'h0703_0102, 2'b10, 1'b1, 0, 0, 32'h0000_0020});
        vecs.push_back('{32'h06FB_0000, 2'b01, 1'b0, 0, 0, 32'h0000_0010});
        vecs.push_back('{32'h0703_0102, 2'b10, 1'b0, 0, 0, 32'h0000_0014});
        vecs.push_back('{32'h06FE_0000, 2'b01, 1'b0, 0, 0, 32'h0000_0010});
        vecs.push_back('{32'h0803_0102, 2'b11, 1'b0, 0, 0, 32'h0000_0020});
        vecs.push_back('{32'h06FB_0000, 2'b01, 1'b1, 0, 0, 32'h0000_0010});
        vecs.push_back('{32'h0803_0102, 2'b11, 1'b1, 0, 0, 32'h0000_0014});
        vecs.push_back('{32'hFF7F_1234, 2'b00, 1'b1, 1, 3, 32'h0000_0018});
        vecs.push_back('{32'h0680_0000, 2'b01, 1'b0, 0, 0, 32'hFFFF_FE1C});
        vecs.push_back('{32'h0638_0000, 2'b01, 1'b0, 0, 0, 32'hFFFF_FF00});
        vecs.push_back('{32'h067F_0000, 2'b01, 1'b0, 2, 1, 32'h0000_0100});

        repeat (2) @(negedge clk);
        check("rst_pc", pc, 32'h0);
        check("rst_imem_read", {31'd0, imem_read}, 32'd0);
        check("rst_valid", {31'd0, instr_valid}, 32'd0);
        check("rst_retire", retire_count, 32'h0);
        check("rst_instr", instruction, 32'h0);
        reset_n = 1'b1;
        #1;
        check("idle_imem_read", {31'd0, imem_read}, 32'd0);
        @(negedge clk);
        check("first_fetch_read", {31'd0, imem_read}, 32'd1);
        check("first_fetch_addr", imem_addr, 32'h0);

        foreach (vecs[i]) run_vec(vecs[i]);
        wait_fetch("wrap");

        // Asynchronous reset in the middle of a busy fetch.
        #2 reset_n = 1'b0;
        #1;
        check("async_imem_read", {31'd0, imem_read}, 32'd0);
        check("async_pc", pc, 32'h0);
        check("async_retire", retire_count, 32'h0);
        check("async_valid", {31'd0, instr_valid}, 32'd0);
        imem_busywait = 1'b0;
        imem_rdata    = 32'h1122_3344;
        @(negedge clk);
        imem_busywait = 1'b1;
        imem_rdata    = 32'hDEAD_BEEF;
        reset_n       = 1'b1;
        pc_exp        = 32'h0;
        ret_exp       = 32'h0;
        @(negedge clk);
        check("late_rdata_not_latched", instruction, 32'h0);
        run_vec('{32'h0203_0405, 2'b00, 1'b0, 1, 0, 32'h0000_0004});
        wait_fetch("post_reset");
        repeat (2) @(negedge clk);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, bad=%0d", bad + 1);
        $fatal(1);
    end

endmodule
